// File: rtl/serial_lane_pkg.sv
// Shared types and constants for the serial detector lane arbiter.
package serial_lane_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } lane_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int unsigned DRAIN_CYCLES = 1;

endpackage

// File: rtl/serial_lane_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; the grant is combinational, the history updates on accept.
module rr_arbiter2
  import serial_lane_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_grant
);

  logic r_last_grant;

  // A tie goes to the requester that did not win last; otherwise the lone valid wins.
  always_comb begin
    o_grant = REQ0;
    if (i_valid0 && i_valid1) begin
      o_grant = ~r_last_grant;
    end else if (i_valid1) begin
      o_grant = REQ1;
    end
  end

  // Remember who won the most recent accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= REQ1;
    end else if (i_accept) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/serial_lane_arbiter.sv
// Shares one external serial bit-detector between two word requesters and
// reports, per word, how many sample cycles the detector output was high.
module serial_lane_arbiter
  import serial_lane_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_rst,
  output logic             det_in,
  input  logic             det_out,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  output logic             res_hit
);

  localparam int BIT_W = $clog2(WIDTH);

  lane_state_t      r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bitcnt;
  logic [CNT_W-1:0] r_count;
  logic             r_owner;
  logic             r_res_valid;
  logic             r_res_id;
  logic [CNT_W-1:0] r_res_count;
  logic             r_res_hit;

  logic w_grant;
  logic w_idle;
  logic w_accept;

  assign w_idle     = (r_state == IDLE) && !rst;
  assign req0_ready = w_idle && req0_valid && (w_grant == REQ0);
  assign req1_ready = w_idle && req1_valid && (w_grant == REQ1);
  assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Detector is cleared by block reset as well as before every word.
  assign det_rst = rst || (r_state == CLR);
  assign det_in  = !rst && (r_state == SHIFT) && r_shift[WIDTH-1];

  // Result fields read as zero while reset is held, even before the registers clear.
  assign res_valid = !rst && r_res_valid;
  assign res_id    = !rst && r_res_id;
  assign res_count = rst ? '0 : r_res_count;
  assign res_hit   = !rst && r_res_hit;

  // Lane sequencer: accept, clear detector, shift word out, drain, publish result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_count     <= '0;
      r_owner     <= REQ0;
      r_res_valid <= 1'b0;
      r_res_id    <= REQ0;
      r_res_count <= '0;
      r_res_hit   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= (w_grant == REQ1) ? req1_data : req0_data;
            r_owner <= w_grant;
            r_state <= CLR;
          end
        end
        CLR: begin
          r_count  <= '0;
          r_bitcnt <= '0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          // The first SHIFT cycle still shows the cleared detector, so it is not sampled.
          if ((r_bitcnt != '0) && det_out) begin
            r_count <= r_count + 1'b1;
          end
          if (r_bitcnt == BIT_W'(WIDTH - 1)) begin
            r_state <= DRAIN;
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        DRAIN: begin
          // Final sample reflects the last data bit; fold it straight into the result.
          r_res_valid <= 1'b1;
          r_res_id    <= r_owner;
          r_res_count <= r_count + CNT_W'(det_out);
          r_res_hit   <= (r_count != '0) || det_out;
          r_state     <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Self-checking bench for serial_lane_arbiter with a "last two bits both 1" detector.
module tb_serial_lane_arbiter;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1;
  logic [W-1:0]  d0, d1;
  logic          req0_ready, req1_ready;
  logic          det_rst, det_in;
  logic          m_p, m_out;
  logic          res_valid, res_id, res_hit;
  logic [CW-1:0] res_count;

  int n_err;
  int n_checks;

  logic         m_last;
  int           prev_cnt;
  logic         prev_id;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  always #5 clk = ~clk;

  serial_lane_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v0),
    .req0_data  (d0),
    .req0_ready (req0_ready),
    .req1_valid (v1),
    .req1_data  (d1),
    .req1_ready (req1_ready),
    .det_rst    (det_rst),
    .det_in     (det_in),
    .det_out    (m_out),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_count  (res_count),
    .res_hit    (res_hit)
  );

  // External detector: registered output is high when the last two bits seen were both 1.
  always @(posedge clk) begin
    if (det_rst) begin
      m_p   <= 1'b0;
      m_out <= 1'b0;
    end else begin
      m_out <= m_p & det_in;
      m_p   <= det_in;
    end
  end

  function automatic int pairs(input logic [W-1:0] w);
    int c = 0;
    for (int i = 0; i < W - 1; i++) if (w[i] && w[i+1]) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refill(input logic win);
    if (win) begin
      if (q1.size() > 0) d1 = q1.pop_front(); else v1 = 1'b0;
    end else begin
      if (q0.size() > 0) d0 = q0.pop_front(); else v0 = 1'b0;
    end
  endtask

  task automatic present();
    if (!v0 && q0.size() > 0) begin d0 = q0.pop_front(); v0 = 1'b1; end
    if (!v1 && q1.size() > 0) begin d1 = q1.pop_front(); v1 = 1'b1; end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    m_last   = 1'b1;
    prev_cnt = 0;
    prev_id  = 1'b0;
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_res_valid", res_valid, 0);
      chk("idle_ready0", req0_ready, 0);
      chk("idle_ready1", req1_ready, 0);
    end
  endtask

  // Waits for the model's handshake, then traces the word through to its result.
  task automatic serve(input int late_req, input logic [W-1:0] late_word, input int rst_at,
                       output logic win, output int gap);
    logic [W-1:0] w;
    int           exp_cnt;
    bit           hs;
    hs  = 1'b0;
    gap = 0;
    win = 1'b0;
    while (!hs && gap < 60) begin
      @(negedge clk);
      gap++;
      win = (v0 && v1) ? ~m_last : v1;
      chk("wait_ready0", req0_ready, v0 && !win);
      chk("wait_ready1", req1_ready, v1 && win);
      chk("wait_res_valid", res_valid, 0);
      chk("hold_res_count", res_count, prev_cnt);
      chk("hold_res_id", res_id, prev_id);
      hs = (v0 && !win) || (v1 && win);
    end
    if (!hs) begin
      n_checks++;
      n_err++;
      $error("FAIL hs_timeout: got no handshake expected one within 60 cycles");
      return;
    end
    w       = win ? d1 : d0;
    exp_cnt = pairs(w);
    m_last  = win;
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) refill(win);
      if (k == 4 && late_req == 0) begin d0 = late_word; v0 = 1'b1; end
      if (k == 4 && late_req == 1) begin d1 = late_word; v1 = 1'b1; end
      if (rst_at != 0 && k == rst_at) rst = 1'b1;
      if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
      @(negedge clk);
      if (rst_at != 0 && k == rst_at + 1) begin
        m_last   = 1'b1;
        prev_cnt = 0;
        prev_id  = 1'b0;
        return;
      end
      chk("busy_ready0", req0_ready, 0);
      chk("busy_ready1", req1_ready, 0);
      chk("det_rst", det_rst, (k == 1) || (k == rst_at));
      chk("det_in", det_in, (k >= 2 && k <= W + 1 && k != rst_at) ? w[W+1-k] : 1'b0);
      if (k == W + 3) begin
        chk("res_valid", res_valid, 1);
        chk("res_id", res_id, win);
        chk("res_count", res_count, exp_cnt);
        chk("res_hit", res_hit, exp_cnt != 0);
        prev_cnt = exp_cnt;
        prev_id  = win;
      end else begin
        chk("early_res_valid", res_valid, 0);
        chk("busy_res_count", res_count, (k == rst_at) ? 0 : prev_cnt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic win;
    int   gap;
    n_err    = 0;
    n_checks = 0;
    rst      = 1'b1;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    m_last   = 1'b1;
    prev_cnt = 0;
    prev_id  = 1'b0;

    // Reset values while rst is held.
    @(posedge clk); @(negedge clk);
    chk("rst_det_rst", det_rst, 1);
    chk("rst_det_in", det_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_hit", res_hit, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check(3);

    // Single word from requester 0.
    @(posedge clk); #1;
    d0 = 8'h6E; v0 = 1'b1;
    serve(-1, '0, 0, win, gap);
    chk("single_count", res_count, 3);
    chk("single_id", res_id, 0);

    // Data extremes from requester 1.
    @(posedge clk); #1;
    d1 = 8'h00; v1 = 1'b1;
    q1.push_back(8'hFF);
    serve(-1, '0, 0, win, gap);
    chk("zero_count", res_count, 0);
    chk("zero_hit", res_hit, 0);
    serve(-1, '0, 0, win, gap);
    chk("ones_count", res_count, 7);
    chk("ones_hit", res_hit, 1);

    // Round-robin with both requesters continuously valid from reset.
    do_reset(2);
    d0 = 8'hA5; v0 = 1'b1;
    d1 = 8'h3C; v1 = 1'b1;
    q0.push_back(8'hB7);
    q1.push_back(8'h1E);
    for (int i = 0; i < 4; i++) begin
      serve(-1, '0, 0, win, gap);
      chk("rr_res_id", res_id, i % 2);
      if (i > 0) chk("rr_spacing", gap, 1);
    end

    // Requester 1 raises valid while requester 0's word is shifting.
    @(posedge clk); #1;
    d0 = 8'($urandom); v0 = 1'b1;
    serve(1, 8'($urandom), 0, win, gap);
    chk("busy_first_id", res_id, 0);
    serve(-1, '0, 0, win, gap);
    chk("busy_second_id", res_id, 1);
    chk("busy_second_gap", gap, 1);
    idle_check(4);

    // Reset in the middle of SHIFT drops the word; next tie goes to requester 0.
    @(posedge clk); #1;
    d0 = 8'($urandom); v0 = 1'b1;
    serve(-1, '0, 5, win, gap);
    idle_check(15);
    @(posedge clk); #1;
    d0 = 8'($urandom); v0 = 1'b1;
    d1 = 8'($urandom); v1 = 1'b1;
    serve(-1, '0, 0, win, gap);
    chk("post_rst_tie_id", res_id, 0);
    serve(-1, '0, 0, win, gap);
    chk("post_rst_next_id", res_id, 1);

    // Randomized bursts from both sides.
    for (int r = 0; r < 5; r++) begin
      int n0;
      int n1;
      int guard;
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range(0, 3));
      for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      present();
      guard = 0;
      while ((v0 || v1) && guard < 10) begin
        serve(-1, '0, 0, win, gap);
        guard++;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
